// File: rtl/xor_parity_rx.sv
// xor_parity_rx: receives one framed serial word.
// Frame layout: start bit, DATA_W data bits sent LSB first, parity bit, stop bit.
// The block recomputes XOR parity over the data bits and the parity bit and
// compares it with the received parity bit. It reports the received word, a
// parity error flag, a framing error flag and a saturating error count.
// The serial line is sampled only on cycles where bit_en strobes high.
module xor_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  // Wide enough to hold any count from 0 to DATA_W.
  localparam int BC_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_next;
  logic [BC_W-1:0]     r_bit_cnt;
  logic                r_par;
  logic                r_pend_err;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_valid;
  logic                r_parity_err;
  logic                r_frame_err;
  logic [CNT_W-1:0]    r_err_count;
  logic                w_last_bit;
  logic                w_frame_bad;

  // Each new bit enters at the MSB. After DATA_W shifts, the first bit
  // received has moved down to bit 0.
  if (DATA_W == 1) begin : g_shift_1
    assign w_shift_next = rx_in;
  end else begin : g_shift_n
    assign w_shift_next = {rx_in, r_shift[DATA_W-1:1]};
  end

  assign w_last_bit  = (r_bit_cnt == BC_W'(DATA_W - 1));
  assign w_frame_bad = r_pend_err | ~rx_in;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so that every register
    // samples the values from before the edge, whatever the statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. The state changes only on sample strobes.
  always_comb begin
    // NOTE: assigning the default first means every path drives w_next, so
    // synthesis infers no latch.
    w_next = r_state;
    if (bit_en) begin
      case (r_state)
        S_IDLE:   if (!rx_in) w_next = S_DATA;
        S_DATA:   if (w_last_bit) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: shifts in the data bits, tracks parity, latches the results at
  // the stop bit and counts errored frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_pend_err   <= 1'b0;
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!rx_in) begin
              r_bit_cnt <= '0;
              r_par     <= 1'b0;
            end
          end
          S_DATA: begin
            r_shift   <= w_shift_next;
            r_par     <= r_par ^ rx_in;
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
          end
          S_PARITY: begin
            r_pend_err <= r_par ^ rx_in ^ ODD_PARITY;
          end
          S_STOP: begin
            r_data_out   <= r_shift;
            r_parity_err <= r_pend_err;
            r_frame_err  <= ~rx_in;
            r_valid      <= 1'b1;
            // The counter stops at all-ones and stays there until reset.
            if (w_frame_bad && (r_err_count != {CNT_W{1'b1}}))
              r_err_count <= r_err_count + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_xor_parity_rx.sv
// Testbench for xor_parity_rx. Two instances share the same serial line:
// u_even uses even parity with an 8-bit counter, and u_odd uses odd parity
// with a 2-bit counter. Expected results come from a frame-level model that
// counts the 1s in each frame.
module tb_xor_parity_rx;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       bit_en = 1'b0;
  logic       rx_in  = 1'b1;

  logic [7:0] d0, d1;
  logic       dv0, dv1, pe0, pe1, fe0, fe1, b0, b1;
  logic [7:0] ec0;
  logic [1:0] ec1;

  int tests = 0;
  int fails = 0;

  // Pulse monitor: counts data_valid pulses and flags any pulse that lasts
  // longer than one cycle.
  int   vcnt0 = 0, vcnt1 = 0, long0 = 0, long1 = 0;
  logic pdv0 = 1'b0, pdv1 = 1'b0;

  // Reference model state.
  int   exp_frames = 0;
  int   exp_err0   = 0;
  int   exp_err1   = 0;
  logic snap_dv0, snap_dv1;

  always #5 clk = ~clk;

  xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
    .data_out(d0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0),
    .busy(b0), .err_count(ec0)
  );

  xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1), .CNT_W(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
    .data_out(d1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1),
    .busy(b1), .err_count(ec1)
  );

  // Watch data_valid on falling edges, away from the active clock edge.
  always @(negedge clk) begin
    if (dv0) vcnt0++;
    if (dv0 && pdv0) long0++;
    pdv0 = dv0;
    if (dv1) vcnt1++;
    if (dv1 && pdv1) long1++;
    pdv1 = dv1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one line bit with a single-cycle bit_en strobe; strobes are 4 cycles
  // apart. data_valid is captured in the cycle after the sampling edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_in  = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    #1;
    snap_dv0 = dv0;
    snap_dv1 = dv1;
    repeat (2) @(negedge clk);
  endtask

  // Sends one full frame, then checks both instances against the model.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input string tag);
    int   ones;
    logic exp_pe_even, exp_pe_odd;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    ones        = $countones(d) + int'(p);
    exp_pe_even = (ones % 2) != 0;
    exp_pe_odd  = (ones % 2) != 1;
    exp_frames++;
    if (exp_pe_even || !s) exp_err0 = (exp_err0 < 255) ? exp_err0 + 1 : 255;
    if (exp_pe_odd  || !s) exp_err1 = (exp_err1 < 3)   ? exp_err1 + 1 : 3;
    check({tag, " dv0"},    32'(snap_dv0), 32'd1);
    check({tag, " dv1"},    32'(snap_dv1), 32'd1);
    check({tag, " vcnt0"},  32'(vcnt0),    32'(exp_frames));
    check({tag, " vcnt1"},  32'(vcnt1),    32'(exp_frames));
    check({tag, " data0"},  32'(d0),       32'(d));
    check({tag, " data1"},  32'(d1),       32'(d));
    check({tag, " perr0"},  32'(pe0),      32'(exp_pe_even));
    check({tag, " perr1"},  32'(pe1),      32'(exp_pe_odd));
    check({tag, " ferr0"},  32'(fe0),      32'(!s));
    check({tag, " ferr1"},  32'(fe1),      32'(!s));
    check({tag, " ecnt0"},  32'(ec0),      32'(exp_err0));
    check({tag, " ecnt1"},  32'(ec1),      32'(exp_err1));
    check({tag, " busy0"},  32'(b0),       32'd0);
  endtask

  // Asserts reset away from a clock edge, checks the cleared outputs, then
  // releases reset.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " data0"}, 32'(d0),  32'd0);
    check({tag, " dv0"},   32'(dv0), 32'd0);
    check({tag, " perr0"}, 32'(pe0), 32'd0);
    check({tag, " ferr0"}, 32'(fe0), 32'd0);
    check({tag, " busy0"}, 32'(b0),  32'd0);
    check({tag, " busy1"}, 32'(b1),  32'd0);
    check({tag, " ecnt0"}, 32'(ec0), 32'd0);
    check({tag, " ecnt1"}, 32'(ec1), 32'd0);
    rx_in    = 1'b1;
    rst_n    = 1'b1;
    exp_err0 = 0;
    exp_err1 = 0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp, rs;
    int         vsave;

    #2 rst_n = 1'b0;
    #20;
    check("reset data0", 32'(d0),  32'd0);
    check("reset dv0",   32'(dv0), 32'd0);
    check("reset busy0", 32'(b0),  32'd0);
    check("reset ecnt0", 32'(ec0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // An idle line keeps the receiver in IDLE.
    repeat (3) send_bit(1'b1);
    check("idle busy0", 32'(b0),    32'd0);
    check("idle vcnt0", 32'(vcnt0), 32'd0);

    send_frame(8'hA5, 1'b0, 1'b1, "good_a5");
    send_frame(8'hA5, 1'b1, 1'b1, "perr_a5");
    send_frame(8'h3C, 1'b0, 1'b0, "ferr_3c");

    // Back-to-back frames with no idle bits between them.
    send_frame(8'h01, 1'b1, 1'b1, "b2b_01");
    send_frame(8'hFF, 1'b0, 1'b1, "b2b_ff");

    // Abort a frame with reset after 4 data bits.
    vsave = vcnt0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("midframe busy0", 32'(b0), 32'd1);
    do_reset("midreset");
    repeat (12) send_bit(1'b1);
    check("aborted no_dv", 32'(vcnt0), 32'(vsave));
    send_frame(8'h5A, 1'b0, 1'b1, "after_rst_5a");

    // On the odd-parity instance, 00 with parity 0 is an error each time,
    // and the 2-bit counter saturates at 3.
    do_reset("pre_sat");
    for (int i = 0; i < 5; i++) send_frame(8'h00, 1'b0, 1'b1, $sformatf("sat%0d", i));
    check("sat final ecnt1", 32'(ec1), 32'd3);

    // Random frames, some with bad parity or a bad stop bit, separated by
    // random idle gaps.
    for (int n = 0; n < 30; n++) begin
      rd = 8'($urandom);
      rp = (^rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 5) != 0);
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
      send_frame(rd, rp, rs, $sformatf("rand%0d", n));
    end

    check("pulse width 0", 32'(long0), 32'd0);
    check("pulse width 1", 32'(long1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
- Serial receiver at the far end of an XOR-parity-protected serial link: deserialises one framed word, recomputes XOR parity and checks it against the received parity bit.
- Frame format: start bit, DATA_W data bits LSB-first, parity bit, stop bit.
- Sits between the line interface and downstream word-level logic. Reports received data, parity and framing errors, and a saturating error count.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 1..32).
- ODD_PARITY, 0. When 0 the link uses even parity: the XOR of data bits and parity bit must be 0. When 1 the link uses odd parity: the XOR must be 1.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_en  input  1  one-cycle strobe marking the bit-centre sample point; rx_in is sampled only when bit_en=1.
- rx_in  input  1  serial line; idle level is 1.
- data_out  output  DATA_W  last received word; held until the next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity result of the last frame; valid with data_out.
- frame_err  output  1  stop-bit result of the last frame; 1 means the stop bit was sampled as 0.
- busy  output  1  high whenever the state is not IDLE.
- err_count  output  CNT_W  count of frames with parity_err or frame_err set; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
  - Shift register, bit counter and running parity are cleared.
  - Asserting reset mid-frame aborts the frame: no data_valid, counters unchanged beyond the reset clear.
- FSM: IDLE, DATA, PARITY, STOP. Transitions happen only on edges where bit_en=1. With bit_en=0 all state holds, except that data_valid drops.
- IDLE:
  - rx_in=0 goes to DATA; bit counter and running parity are cleared.
  - rx_in=1 stays in IDLE.
- DATA:
  - Each bit_en shifts rx_in into the MSB of the shift register (right shift), so that after DATA_W bits, bit 0 of the word holds the first data bit received.
  - The running parity is XORed with rx_in.
  - After the DATA_W-th bit, go to PARITY.
- PARITY:
  - Compute par = running parity XOR rx_in XOR ODD_PARITY.
  - The pending error is par != 0.
  - Go to STOP.
- STOP, on the bit_en edge:
  - data_out is loaded with the shift register.
  - parity_err is loaded with the pending error.
  - frame_err is set to (rx_in==0).
  - data_valid=1 on the following cycle only (registered; exactly one cycle high).
  - Go to IDLE.
- Frame latency: data_valid is high in the cycle after the edge that samples the stop bit.
- Back-to-back frames: a start bit may be sampled on the very next bit_en after the stop bit. That sample is taken in IDLE, even if data_valid is high in the same cycle.
- Stop bit sampled as 0: the frame still completes with frame_err=1. The FSM returns to IDLE; there is no resynchronisation search beyond normal start detection.
- err_count:
  - Increments by 1 on the same edge that loads the flags, if (pending parity error OR stop bit==0).
  - Holds at 2^CNT_W-1 once reached.
  - Cleared only by reset.
- parity_err and frame_err hold their values until the next frame completes.

Test Plan:
- Good frame, defaults: bit_en every 4 cycles; line sequence 0, then data bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_valid one-cycle pulse; data_out=8'hA5, parity_err=0, frame_err=0, err_count=0.
- Parity error: same frame with parity bit 1 -> data_out=8'hA5, parity_err=1, frame_err=0, err_count=1.
- Framing error: 8'h3C sent (parity 0) with stop bit 0 -> data_out=8'h3C, frame_err=1, parity_err=0, err_count increments by 1.
- Back-to-back frames: 8'h01 (parity 1) immediately followed by 8'hFF (parity 0), no idle bits between them -> two data_valid pulses, data_out=8'h01 then 8'hFF, no errors.
- Reset mid-frame: rst_n pulled low after 4 data bits, then released, then a clean 8'h5A frame sent -> no data_valid for the aborted frame; next data_out=8'h5A, err_count=0.
- Odd parity with saturation: ODD_PARITY=1, CNT_W=2; five frames of 8'h00 with parity bit 0 -> each frame parity_err=1; err_count reads 1, 2, 3, 3, 3.
